// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and the decoder.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned CNT_W = 3;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  localparam logic [5:0] OPC_BEZ = 6'b101000;
  localparam logic [5:0] OPC_BNE = 6'b101001;
  localparam logic [5:0] OPC_JMP = 6'b101010;

  function automatic logic [31:0] pc_add4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues addresses to instruction memory,
// captures the returned word into IR and hands it over with a valid/ack handshake.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        ir_ack,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc_plus4,
  output logic        ir_valid,
  output logic        busy,
  output logic        misalign_err
);

  localparam logic [CNT_W-1:0] LAT        = CNT_W'(MEM_LATENCY);
  localparam bit               LAT_ZERO   = (MEM_LATENCY == 0);
  localparam logic [31:0]      RESET_PC_W = {RESET_PC[31:2], 2'b00};

  fetch_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      pc_q;
  logic [31:0]      ir_q;
  logic [31:0]      ir_pc_q;
  logic [31:0]      ir_pc_plus4_q;
  logic             ir_valid_q;
  logic             busy_q;
  logic             misalign_q;

  logic wait_done_c;
  logic issue_c;
  logic capture_c;
  logic redirect_issue_c;

  // A redirected fetch can never capture on the redirect edge itself: the old
  // address is still on the bus, so a zero-latency ROM needs one WAIT cycle.
  assign wait_done_c      = LAT_ZERO || (cnt_q == LAT);
  assign issue_c          = fetch_req && ((state_q == S_IDLE) ||
                                          ((state_q == S_HOLD) && ir_ack));
  assign capture_c        = (issue_c && LAT_ZERO) ||
                            ((state_q == S_WAIT) && wait_done_c);
  assign redirect_issue_c = (state_q == S_WAIT) || issue_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pc_q          <= RESET_PC_W;
      ir_q          <= INSTR_NOP;
      ir_pc_q       <= '0;
      ir_pc_plus4_q <= '0;
      ir_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        // Redirect beats capture; any in-flight or pending fetch restarts at the target.
        pc_q       <= {redirect_pc[31:2], 2'b00};
        ir_valid_q <= 1'b0;
        if (redirect_issue_c) begin
          state_q <= S_WAIT;
          busy_q  <= 1'b1;
          cnt_q   <= CNT_W'(1);
        end else begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      end else if (capture_c) begin
        ir_q          <= imem_data;
        ir_pc_q       <= pc_q;
        ir_pc_plus4_q <= pc_add4(pc_q);
        pc_q          <= pc_add4(pc_q);
        ir_valid_q    <= 1'b1;
        state_q       <= S_HOLD;
        busy_q        <= 1'b0;
        cnt_q         <= '0;
      end else if (issue_c) begin
        state_q    <= S_WAIT;
        busy_q     <= 1'b1;
        cnt_q      <= CNT_W'(1);
        ir_valid_q <= 1'b0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if ((state_q == S_HOLD) && ir_ack) begin
        state_q    <= S_IDLE;
        ir_valid_q <= 1'b0;
      end
    end
  end

  assign imem_addr    = {pc_q[31:2], 2'b00};
  assign pc           = pc_q;
  assign ir           = ir_q;
  assign ir_pc        = ir_pc_q;
  assign ir_pc_plus4  = ir_pc_plus4_q;
  assign ir_valid     = ir_valid_q;
  assign busy         = busy_q;
  assign misalign_err = misalign_q;

endmodule
